exception_ctrl: RTL and testbench

Pipeline-side exception front end for the MIPS core: collects per-stage exception flags of the instruction in MEM, priority-encodes them into the one-hot exception vector and PC/address/delay-slot context that the CP0 register block consumes, then takes CP0's flush and return-PC response and sequences the pipeline flush and fetch redirect. It sits between the MEM stage, CP0 and the fetch unit. It issues one exception per instruction and holds the pipeline until CP0 has answered.

---
 rtl/exception_ctrl_pkg.sv | 37 +++
 rtl/exception_ctrl_prio_enc.sv | 36 +++
 rtl/exception_ctrl.sv | 126 ++++++++++++
 tb/tb_exception_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_ctrl_pkg.sv
// Shared types and constants for the exception front end: flag indices,
// exception_type bit positions, FSM state encoding and address-select codes.
package exception_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned FLAG_W = 8;

  localparam int unsigned FLAG_FETCH_ADEL = 7;
  localparam int unsigned FLAG_RI         = 6;
  localparam int unsigned FLAG_OV         = 5;
  localparam int unsigned FLAG_BP         = 4;
  localparam int unsigned FLAG_SYS        = 3;
  localparam int unsigned FLAG_DATA_ADEL  = 2;
  localparam int unsigned FLAG_ADES       = 1;
  localparam int unsigned FLAG_ERET       = 0;

  // Flags 7..1 map to exception_type bits 31..25; ERET maps to bit 0.
  localparam int unsigned EXC_BIT_BASE = 24;
  localparam int unsigned EXC_BIT_ERET = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CP0 = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ADDR_NONE = 2'd0,
    ADDR_PC   = 2'd1,
    ADDR_DATA = 2'd2
  } addr_sel_t;

  function automatic logic [XLEN-1:0] exc_bit(input int unsigned flag);
    return XLEN'(1) << ((flag == FLAG_ERET) ? EXC_BIT_ERET : EXC_BIT_BASE + flag);
  endfunction

endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// Priority encoder: highest-index exception flag wins; emits the one-hot
// CP0 exception vector and which address CP0 should record as bad address.
module exc_prio_enc
  import exception_ctrl_pkg::*;
(
  input  logic [FLAG_W-1:0] flags,
  output logic [XLEN-1:0]   exception_type,
  output addr_sel_t         addr_sel
);

  always_comb begin
    exception_type = '0;
    addr_sel       = ADDR_NONE;
    if (flags[FLAG_FETCH_ADEL]) begin
      exception_type = exc_bit(FLAG_FETCH_ADEL);
      addr_sel       = ADDR_PC;
    end else if (flags[FLAG_RI]) begin
      exception_type = exc_bit(FLAG_RI);
    end else if (flags[FLAG_OV]) begin
      exception_type = exc_bit(FLAG_OV);
    end else if (flags[FLAG_BP]) begin
      exception_type = exc_bit(FLAG_BP);
    end else if (flags[FLAG_SYS]) begin
      exception_type = exc_bit(FLAG_SYS);
    end else if (flags[FLAG_DATA_ADEL]) begin
      exception_type = exc_bit(FLAG_DATA_ADEL);
      addr_sel       = ADDR_DATA;
    end else if (flags[FLAG_ADES]) begin
      exception_type = exc_bit(FLAG_ADES);
      addr_sel       = ADDR_DATA;
    end else if (flags[FLAG_ERET]) begin
      exception_type = exc_bit(FLAG_ERET);
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception front end between MEM, CP0 and fetch: issues one exception per
// instruction, waits for CP0, then sequences flush and fetch redirect.
// Optional event counter enabled by EXCEPTION_CTRL_STAT_EN.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int unsigned CP0_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic [XLEN-1:0]   mem_pc_i,
  input  logic              mem_in_delayslot_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [FLAG_W-1:0] excp_flags_i,
  input  logic              cp0_flush_i,
  input  logic [XLEN-1:0]   cp0_return_pc_i,
  output logic [XLEN-1:0]   exception_type_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   exception_addr_o,
  output logic              now_in_delayslot_o,
  output logic              mem_kill_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  input  logic              redirect_ready_i
`ifdef EXCEPTION_CTRL_STAT_EN
  ,
  output logic [XLEN-1:0]   exc_count_o
`endif
);

  localparam int unsigned WAIT_W = (CP0_WAIT > 1) ? $clog2(CP0_WAIT) : 1;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hit;
  logic              accept;
  logic [XLEN-1:0]   enc_type;
  addr_sel_t         addr_sel;
  logic [XLEN-1:0]   bad_addr;

  exc_prio_enc u_prio_enc (
    .flags          (excp_flags_i),
    .exception_type (enc_type),
    .addr_sel       (addr_sel)
  );

  always_comb begin
    bad_addr = '0;
    case (addr_sel)
      ADDR_PC:   bad_addr = mem_pc_i;
      ADDR_DATA: bad_addr = mem_addr_i;
      default:   bad_addr = '0;
    endcase
  end

  // An interrupt flush in IDLE pre-empts a same-cycle exception.
  assign hit        = mem_valid_i & (|excp_flags_i);
  assign accept     = (state == ST_IDLE) & hit & ~cp0_flush_i;
  assign mem_kill_o = accept;
  assign stall_o    = (state == ST_WAIT_CP0) |
                      ((state == ST_REDIRECT) & ~redirect_ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      wait_cnt           <= '0;
      exception_type_o   <= '0;
      pc_o               <= '0;
      exception_addr_o   <= '0;
      now_in_delayslot_o <= 1'b0;
      flush_o            <= 1'b0;
      redirect_valid_o   <= 1'b0;
      redirect_pc_o      <= '0;
    end else begin
      exception_type_o <= '0;
      flush_o          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cp0_flush_i) begin
            state            <= ST_REDIRECT;
            redirect_pc_o    <= cp0_return_pc_i;
            redirect_valid_o <= 1'b1;
            flush_o          <= 1'b1;
          end else if (hit) begin
            state              <= ST_WAIT_CP0;
            wait_cnt           <= '0;
            exception_type_o   <= enc_type;
            pc_o               <= mem_pc_i;
            exception_addr_o   <= bad_addr;
            now_in_delayslot_o <= mem_in_delayslot_i;
          end
        end
        ST_WAIT_CP0: begin
          if (cp0_flush_i) begin
            state            <= ST_REDIRECT;
            redirect_pc_o    <= cp0_return_pc_i;
            redirect_valid_o <= 1'b1;
            flush_o          <= 1'b1;
          end else if (wait_cnt == WAIT_W'(CP0_WAIT - 1)) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready_i) begin
            state            <= ST_IDLE;
            redirect_valid_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef EXCEPTION_CTRL_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) exc_count_o <= '0;
    else if (accept) exc_count_o <= exc_count_o + XLEN'(1);
  end
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Randomized self-checking bench for exception_ctrl against a transaction-level
// reference model of exception priority, CP0 handshake and fetch redirect.
module tb_exception_ctrl;

  localparam int unsigned CP0_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  excp_flags_i;
  logic        cp0_flush_i;
  logic [31:0] cp0_return_pc_i;
  logic [31:0] exception_type_o;
  logic [31:0] pc_o;
  logic [31:0] exception_addr_o;
  logic        now_in_delayslot_o;
  logic        mem_kill_o;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;
`ifdef EXCEPTION_CTRL_STAT_EN
  logic [31:0] exc_count_o;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_count = '0;

  exception_ctrl #(.CP0_WAIT(CP0_WAIT)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_i        (mem_valid_i),
    .mem_pc_i           (mem_pc_i),
    .mem_in_delayslot_i (mem_in_delayslot_i),
    .mem_addr_i         (mem_addr_i),
    .excp_flags_i       (excp_flags_i),
    .cp0_flush_i        (cp0_flush_i),
    .cp0_return_pc_i    (cp0_return_pc_i),
    .exception_type_o   (exception_type_o),
    .pc_o               (pc_o),
    .exception_addr_o   (exception_addr_o),
    .now_in_delayslot_o (now_in_delayslot_o),
    .mem_kill_o         (mem_kill_o),
    .stall_o            (stall_o),
    .flush_o            (flush_o),
    .redirect_valid_o   (redirect_valid_o),
    .redirect_pc_o      (redirect_pc_o),
    .redirect_ready_i   (redirect_ready_i)
`ifdef EXCEPTION_CTRL_STAT_EN
    ,
    .exc_count_o        (exc_count_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: highest set flag wins; flag k>=1 -> bit 24+k, ERET -> bit 0.
  function automatic logic [31:0] model_type(input logic [7:0] f);
    for (int i = 7; i >= 0; i--)
      if (f[i]) return (i == 0) ? 32'h1 : (32'h1 << (24 + i));
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_addr(input logic [7:0] f, input logic [31:0] pc,
                                             input logic [31:0] addr);
    for (int i = 7; i >= 0; i--)
      if (f[i]) begin
        if (i == 7) return pc;
        if (i == 2 || i == 1) return addr;
        return 32'h0;
      end
    return 32'h0;
  endfunction

  task automatic idle_inputs();
    mem_valid_i        = 1'b0;
    excp_flags_i       = 8'($urandom);
    mem_pc_i           = $urandom;
    mem_addr_i         = $urandom;
    mem_in_delayslot_i = 1'($urandom);
    cp0_flush_i        = 1'b0;
    cp0_return_pc_i    = $urandom;
    redirect_ready_i   = 1'b0;
  endtask

  task automatic check_count(input string tag);
`ifdef EXCEPTION_CTRL_STAT_EN
    check({tag, ".count"}, exc_count_o, exp_count);
`else
    if (tag.len() == 0) $display("unreachable");
`endif
  endtask

  // Starts in the first REDIRECT cycle; fetch refuses for 'hold' cycles.
  task automatic redirect_phase(input logic [31:0] ret, input int hold, input string tag);
    for (int i = 0; i <= hold; i++) begin
      redirect_ready_i = (i == hold);
      if (i > 0 && $urandom_range(0, 1) == 1) begin
        cp0_flush_i     = 1'b1;
        cp0_return_pc_i = $urandom;
      end else begin
        cp0_flush_i = 1'b0;
      end
      #1;
      check({tag, ".flush"}, 32'(flush_o), 32'(i == 0));
      check({tag, ".rvalid"}, 32'(redirect_valid_o), 32'h1);
      check({tag, ".rpc"}, redirect_pc_o, ret);
      check({tag, ".rstall"}, 32'(stall_o), 32'(i != hold));
      check({tag, ".rtype"}, exception_type_o, 32'h0);
      step();
    end
    idle_inputs();
    #1;
    check({tag, ".done_valid"}, 32'(redirect_valid_o), 32'h0);
    check({tag, ".done_stall"}, 32'(stall_o), 32'h0);
    check({tag, ".done_flush"}, 32'(flush_o), 32'h0);
  endtask

  // One exception; cp0_delay < 0 means CP0 never answers.
  task automatic run_exc(input logic [7:0] flags, input logic [31:0] pc, input logic [31:0] addr,
                         input logic ds, input int cp0_delay, input int hold,
                         input logic [31:0] ret, input string tag);
    logic [31:0] etype;
    logic [31:0] eaddr;
    etype = model_type(flags);
    eaddr = model_addr(flags, pc, addr);
    mem_valid_i        = 1'b1;
    excp_flags_i       = flags;
    mem_pc_i           = pc;
    mem_addr_i         = addr;
    mem_in_delayslot_i = ds;
    cp0_flush_i        = 1'b0;
    #1;
    check({tag, ".kill"}, 32'(mem_kill_o), 32'h1);
    check({tag, ".stall0"}, 32'(stall_o), 32'h0);
    step();
    exp_count = exp_count + 32'h1;
    idle_inputs();
    #1;
    check({tag, ".type"}, exception_type_o, etype);
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".addr"}, exception_addr_o, eaddr);
    check({tag, ".ds"}, 32'(now_in_delayslot_o), 32'(ds));
    check({tag, ".stall1"}, 32'(stall_o), 32'h1);
    check({tag, ".flush1"}, 32'(flush_o), 32'h0);
    check({tag, ".kill1"}, 32'(mem_kill_o), 32'h0);
    check_count(tag);
    if (cp0_delay < 0) begin
      for (int k = 1; k < CP0_WAIT; k++) begin
        step();
        check({tag, ".wtype"}, exception_type_o, 32'h0);
        check({tag, ".wstall"}, 32'(stall_o), 32'h1);
        check({tag, ".wpc"}, pc_o, pc);
      end
      step();
      check({tag, ".to_stall"}, 32'(stall_o), 32'h0);
      check({tag, ".to_flush"}, 32'(flush_o), 32'h0);
      check({tag, ".to_valid"}, 32'(redirect_valid_o), 32'h0);
    end else begin
      for (int k = 0; k < cp0_delay; k++) begin
        step();
        check({tag, ".wtype"}, exception_type_o, 32'h0);
        check({tag, ".wstall"}, 32'(stall_o), 32'h1);
        check({tag, ".waddr"}, exception_addr_o, eaddr);
      end
      cp0_flush_i     = 1'b1;
      cp0_return_pc_i = ret;
      step();
      idle_inputs();
      redirect_phase(ret, hold, tag);
    end
  endtask

  // Interrupt flush in IDLE, optionally colliding with an exception.
  task automatic run_irq(input logic with_hit, input int hold, input logic [31:0] ret,
                         input string tag);
    mem_valid_i     = with_hit;
    excp_flags_i    = 8'($urandom_range(1, 255));
    cp0_flush_i     = 1'b1;
    cp0_return_pc_i = ret;
    #1;
    check({tag, ".kill"}, 32'(mem_kill_o), 32'h0);
    step();
    idle_inputs();
    redirect_phase(ret, hold, tag);
    check_count(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".type"}, exception_type_o, 32'h0);
    check({tag, ".pc"}, pc_o, 32'h0);
    check({tag, ".addr"}, exception_addr_o, 32'h0);
    check({tag, ".ds"}, 32'(now_in_delayslot_o), 32'h0);
    check({tag, ".stall"}, 32'(stall_o), 32'h0);
    check({tag, ".flush"}, 32'(flush_o), 32'h0);
    check({tag, ".rvalid"}, 32'(redirect_valid_o), 32'h0);
    check({tag, ".rpc"}, redirect_pc_o, 32'h0);
    check({tag, ".kill"}, 32'(mem_kill_o), 32'h0);
    check_count(tag);
  endtask

  initial begin
    logic [31:0] ret;
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    exp_count = '0;
    check_all_zero("reset");
    rst = 1'b0;

    run_exc(8'h40, 32'hBFC0_0100, $urandom, 1'b0, 1, 0, 32'hBFC0_0380, "ri");
    run_exc(8'h86, 32'h8000_0002, 32'h1234_5678, 1'b0, 2, 1, $urandom, "prio");
    run_exc(8'h02, $urandom, 32'h8000_0013, 1'b1, 1, 2, $urandom, "ades_ds");
    run_irq(1'b1, 0, 32'hBFC0_0380, "simul");
    run_exc($urandom_range(1, 255), $urandom, $urandom, 1'($urandom), -1, 0, 0, "timeout");

    // Idle non-events must not trigger anything.
    mem_valid_i  = 1'b1;
    excp_flags_i = 8'h00;
    #1;
    check("idle.kill", 32'(mem_kill_o), 32'h0);
    step();
    idle_inputs();
    #1;
    check("idle.stall", 32'(stall_o), 32'h0);
    check("idle.type", exception_type_o, 32'h0);

    // Backpressure then reset mid-REDIRECT.
    ret = $urandom;
    run_exc($urandom_range(1, 255), $urandom, $urandom, 1'($urandom), -1, 0, 0, "bp_pre");
    mem_valid_i  = 1'b1;
    excp_flags_i = 8'h10;
    mem_pc_i     = 32'h0040_0000;
    step();
    exp_count = exp_count + 32'h1;
    idle_inputs();
    step();
    cp0_flush_i     = 1'b1;
    cp0_return_pc_i = ret;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.flush", 32'(flush_o), 32'(i == 0));
      check("bp.rvalid", 32'(redirect_valid_o), 32'h1);
      check("bp.rpc", redirect_pc_o, ret);
      check("bp.stall", 32'(stall_o), 32'h1);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = '0;
    #1;
    check_all_zero("bp_rst");

    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0)
        run_exc(8'($urandom_range(1, 255)), $urandom, $urandom, 1'($urandom), -1, 0, 0, "rnd_to");
      else if (kind == 3)
        run_irq(1'($urandom), $urandom_range(0, 3), $urandom, "rnd_irq");
      else
        run_exc(8'h1 << $urandom_range(0, 7) | ($urandom_range(0, 1) == 1 ? 8'($urandom) : 8'h0),
                $urandom, $urandom, 1'($urandom), $urandom_range(1, CP0_WAIT - 1),
                $urandom_range(0, 3), $urandom, "rnd_exc");
      if ($urandom_range(0, 2) == 0) step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
